sha256_arbiter: RTL and testbench



---
 rtl/sha256_arbiter.sv | 159 +++++++++++++++
 tb/tb_sha256_arbiter.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_arbiter.sv
// sha256_arbiter: round-robin sharing of one SHA-256 core between
// NUM_REQ pulse-driven hash clients, with an intermediate-chain lock.
module sha256_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int KEY_LEN = 256,
  parameter int REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_hash_start,
  input  logic [NUM_REQ*1024-1:0] req_hash_data_in,
  input  logic [NUM_REQ-1:0]      req_message_length,
  input  logic [NUM_REQ-1:0]      req_continue_intermediate,
  input  logic [NUM_REQ-1:0]      req_store_intermediate,
  output logic [NUM_REQ-1:0]      req_hash_done,
  output logic [KEY_LEN-1:0]      req_hash_data_out,
  output logic                    hash_start,
  output logic [1023:0]           hash_data_in,
  output logic                    message_length,
  output logic                    continue_intermediate,
  output logic                    store_intermediate,
  input  logic                    hash_done,
  input  logic [KEY_LEN-1:0]      hash_data_out,
  output logic                    busy,
  output logic [REQ_W-1:0]        grant_id,
  output logic                    locked,
  output logic                    overflow
);

  localparam int PW = 1027;

  typedef enum logic {IDLE, BUSY} state_e;
  typedef logic [PW-1:0] pay_t;

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      pending_q, pending_d;
  pay_t [NUM_REQ-1:0]      pay_q, pay_d;
  pay_t                    core_q, core_d;
  logic [REQ_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [REQ_W-1:0]        grant_id_q, grant_id_d;
  logic                    locked_q, locked_d;
  logic                    overflow_q, overflow_d;
  logic                    hash_start_q, hash_start_d;

  logic [NUM_REQ-1:0]      owner_vec, elig, grant_vec;
  logic                    found, issue, done_fire;
  logic [REQ_W-1:0]        sel;
  int                      idx;

  function automatic logic [NUM_REQ-1:0] onehot(
    input logic [REQ_W-1:0] id
  );
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // While locked only the chain owner may be served.
  always_comb begin
    owner_vec = onehot(grant_id_q);
    elig      = locked_q ? (pending_q & owner_vec) : pending_q;
    found     = 1'b0;
    sel       = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = REQ_W'(idx);
      end
    end
    issue     = (state_q == IDLE) && found;
    grant_vec = issue ? onehot(sel) : '0;
    done_fire = (state_q == BUSY) && hash_done;
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q & ~grant_vec;
    pay_d        = pay_q;
    core_d       = core_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    locked_d     = locked_q;
    overflow_d   = overflow_q;
    hash_start_d = 1'b0;

    // A pulse in the grant cycle re-arms the slot being vacated.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_hash_start[i]) begin
        if (!pending_q[i] || grant_vec[i]) begin
          pending_d[i] = 1'b1;
          pay_d[i] = {req_store_intermediate[i],
                      req_continue_intermediate[i],
                      req_message_length[i],
                      req_hash_data_in[i*1024 +: 1024]};
        end else begin
          overflow_d = 1'b1;
        end
      end
    end

    if (issue) begin
      state_d      = BUSY;
      hash_start_d = 1'b1;
      core_d       = pay_q[sel];
      grant_id_d   = sel;
    end

    if (done_fire) begin
      state_d  = IDLE;
      rr_ptr_d = (grant_id_q == REQ_W'(NUM_REQ - 1)) ?
                 '0 : grant_id_q + REQ_W'(1);
      if (core_q[PW-1]) begin
        locked_d = 1'b1;
      end else if (core_q[PW-2]) begin
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      pay_q        <= '0;
      core_q       <= '0;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      locked_q     <= 1'b0;
      overflow_q   <= 1'b0;
      hash_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      pay_q        <= pay_d;
      core_q       <= core_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      locked_q     <= locked_d;
      overflow_q   <= overflow_d;
      hash_start_q <= hash_start_d;
    end
  end

  assign req_hash_done         = done_fire ? owner_vec : '0;
  assign req_hash_data_out     = hash_data_out;
  assign hash_start            = hash_start_q;
  assign hash_data_in          = core_q[1023:0];
  assign message_length        = core_q[1024];
  assign continue_intermediate = core_q[1025];
  assign store_intermediate    = core_q[1026];
  assign busy                  = (state_q == BUSY) || (|pending_q);
  assign grant_id              = grant_id_q;
  assign locked                = locked_q;
  assign overflow              = overflow_q;

endmodule

// File: tb/tb_sha256_arbiter.sv
// tb_sha256_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbiter.
module tb_sha256_arbiter;

  localparam int N  = 3;
  localparam int KL = 256;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_start, req_len, req_cont, req_store;
  logic [N-1:0]    req_done;
  logic [N*1024-1:0] req_data;
  logic [KL-1:0]   req_dout, core_dout;
  logic            hs, ml, ci, si, hdone, bsy, lck, ovf;
  logic [1023:0]   hdi;
  logic [1:0]      gid;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit           m_busy, m_start, m_locked, m_ovf;
  int           m_ptr, m_owner;
  bit           m_pend [N];
  logic [1026:0] m_pay [N];
  logic [1026:0] m_out;

  always #5 clk = ~clk;

  sha256_arbiter dut (
    .clk                       (clk),
    .reset                     (reset),
    .req_hash_start            (req_start),
    .req_hash_data_in          (req_data),
    .req_message_length        (req_len),
    .req_continue_intermediate (req_cont),
    .req_store_intermediate    (req_store),
    .req_hash_done             (req_done),
    .req_hash_data_out         (req_dout),
    .hash_start                (hs),
    .hash_data_in              (hdi),
    .message_length            (ml),
    .continue_intermediate     (ci),
    .store_intermediate        (si),
    .hash_done                 (hdone),
    .hash_data_out             (core_dout),
    .busy                      (bsy),
    .grant_id                  (gid),
    .locked                    (lck),
    .overflow                  (ovf)
  );

  task automatic model_reset();
    m_busy = 0; m_start = 0; m_locked = 0; m_ovf = 0;
    m_ptr = 0; m_owner = 0; m_out = '0;
    for (int c = 0; c < N; c++) begin
      m_pend[c] = 0;
      m_pay[c]  = '0;
    end
  endtask

  // One clock edge of the arbiter's behaviour, applied to the
  // inputs currently driven.
  task automatic model_step();
    int g;
    bit done;
    if (!reset) begin
      model_reset();
      return;
    end
    g = -1;
    if (!m_busy)
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (g < 0 && m_pend[c] && (!m_locked || c == m_owner)) g = c;
      end
    done = m_busy && hdone;
    m_start = 0;
    if (g >= 0) begin
      m_out = m_pay[g];
      m_pend[g] = 0;
      m_owner = g;
      m_busy = 1;
      m_start = 1;
    end
    for (int c = 0; c < N; c++)
      if (req_start[c]) begin
        if (!m_pend[c]) begin
          m_pend[c] = 1;
          m_pay[c] = {req_store[c], req_cont[c], req_len[c],
                      req_data[c*1024 +: 1024]};
        end else begin
          m_ovf = 1;
        end
      end
    if (done) begin
      m_busy = 0;
      m_ptr = (m_owner + 1) % N;
      if (m_out[1026]) m_locked = 1;
      else if (m_out[1025]) m_locked = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    req_start = '0;
    hdone = 1'b0;
  endtask

  task automatic pulse(input int c, input logic [1023:0] d,
                       input bit len, input bit cont, input bit st);
    req_start[c] = 1'b1;
    req_data[c*1024 +: 1024] = d;
    req_len[c]   = len;
    req_cont[c]  = cont;
    req_store[c] = st;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_start = '0;
    hdone = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (hs === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  function automatic logic [1023:0] rnd_blk();
    logic [1023:0] d;
    for (int w = 0; w < 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if (hs !== 1'b0 || hdi !== '0) begin
      n_fail++;
      $display("FAIL reset_core: start=%b data_nz=%b", hs, |hdi);
    end
    n_checks++;
    if ({ml, ci, si} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000", {ml, ci, si});
    end
    n_checks++;
    if ({bsy, lck, ovf} !== 3'b000 || gid !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_status: got b%b l%b o%b g%0d want 0",
               bsy, lck, ovf, gid);
    end
    n_checks++;
    if (req_done !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_done: got %b want 000", req_done);
    end
  endtask

  task automatic test_single();
    logic [1023:0] d;
    logic [KL-1:0] dg;
    d  = {128{8'hA5}};
    dg = {8{$urandom}};
    do_reset();
    pulse(1, d, 1'b1, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (hs !== 1'b0 || bsy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_t1: start=%b busy=%b want 0/1", hs, bsy);
    end
    tick();
    n_checks++;
    if (hs !== 1'b1 || hdi !== d || ml !== 1'b1 || gid !== 2'd1) begin
      n_fail++;
      $display("FAIL single_issue: start=%b ml=%b gid=%0d dok=%b",
               hs, ml, gid, hdi === d);
    end
    tick();
    n_checks++;
    if (hs !== 1'b0 || hdi !== d) begin
      n_fail++;
      $display("FAIL single_hold: start=%b dok=%b", hs, hdi === d);
    end
    hdone = 1'b1;
    core_dout = dg;
    #1;
    n_checks++;
    if (req_done !== 3'b010 || req_dout !== dg) begin
      n_fail++;
      $display("FAIL single_done: got %b want 010 dok=%b",
               req_done, req_dout === dg);
    end
    tick();
    n_checks++;
    if (bsy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy: got %b want 0", bsy);
    end
  endtask

  task automatic test_fairness();
    logic [1023:0] fd [N];
    int exp_g [6];
    bit ok;
    exp_g = '{0, 1, 2, 0, 1, 2};
    do_reset();
    for (int c = 0; c < N; c++) begin
      fd[c] = rnd_blk();
      pulse(c, fd[c], 1'b0, 1'b0, 1'b0);
    end
    tick();
    for (int n = 0; n < 6; n++) begin
      wait_start(ok);
      n_checks++;
      if (!ok || gid !== 2'(exp_g[n]) || hdi !== fd[exp_g[n]]) begin
        n_fail++;
        $display("FAIL fair_grant%0d: ok=%b got %0d want %0d", n, ok,
                 gid, exp_g[n]);
      end
      tick();
      hdone = 1'b1;
      if (n < 3) pulse(exp_g[n], fd[exp_g[n]], 1'b0, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (req_done !== (3'b001 << exp_g[n])) begin
        n_fail++;
        $display("FAIL fair_done%0d: got %b want %b", n, req_done,
                 3'b001 << exp_g[n]);
      end
      tick();
    end
  endtask

  task automatic test_lock();
    do_reset();
    pulse(0, rnd_blk(), 1'b0, 1'b0, 1'b1);
    pulse(2, rnd_blk(), 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    n_checks++;
    if (hs !== 1'b1 || gid !== 2'd0 || si !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_first: start=%b gid=%0d st=%b", hs, gid, si);
    end
    tick();
    hdone = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (hs !== 1'b0 || lck !== 1'b1 || bsy !== 1'b1) begin
        n_fail++;
        $display("FAIL lock_wait%0d: start=%b lock=%b busy=%b",
                 i, hs, lck, bsy);
      end
      tick();
    end
    pulse(0, rnd_blk(), 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    n_checks++;
    if (hs !== 1'b1 || gid !== 2'd0 || ci !== 1'b1 || lck !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_second: start=%b gid=%0d ci=%b lock=%b",
               hs, gid, ci, lck);
    end
    tick();
    hdone = 1'b1;
    tick();
    n_checks++;
    if (lck !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_release: got %b want 0", lck);
    end
    tick();
    n_checks++;
    if (hs !== 1'b1 || gid !== 2'd2) begin
      n_fail++;
      $display("FAIL lock_third: start=%b gid=%0d want 1/2", hs, gid);
    end
    tick();
    hdone = 1'b1;
    tick();
  endtask

  task automatic test_overflow();
    logic [1023:0] da, db, dc;
    da = rnd_blk();
    db = rnd_blk();
    dc = rnd_blk();
    do_reset();
    pulse(1, da, 1'b0, 1'b0, 1'b0);
    tick();
    pulse(1, db, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (hs !== 1'b1 || hdi !== da || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_regrant1: start=%b ovf=%b", hs, ovf);
    end
    tick();
    hdone = 1'b1;
    tick();
    tick();
    n_checks++;
    if (hs !== 1'b1 || hdi !== db || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_regrant2: start=%b ovf=%b", hs, ovf);
    end
    tick();
    hdone = 1'b1;
    tick();

    do_reset();
    pulse(0, rnd_blk(), 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    pulse(2, da, 1'b0, 1'b0, 1'b0);
    tick();
    pulse(2, db, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got %b want 1", ovf);
    end
    hdone = 1'b1;
    tick();
    pulse(2, dc, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (hs !== 1'b1 || gid !== 2'd2 || hdi !== da || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_issue: start=%b gid=%0d ovf=%b dok=%b",
               hs, gid, ovf, hdi === da);
    end
    tick();
    hdone = 1'b1;
    tick();
    tick();
    n_checks++;
    if (hs !== 1'b1 || hdi !== dc || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: start=%b ovf=%b dok=%b",
               hs, ovf, hdi === dc);
    end
    tick();
    hdone = 1'b1;
    tick();
  endtask

  task automatic test_spurious();
    do_reset();
    pulse(2, rnd_blk(), 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    hdone = 1'b1;
    tick();
    hdone = 1'b1;
    #1;
    n_checks++;
    if (req_done !== 3'b000) begin
      n_fail++;
      $display("FAIL spur_done: got %b want 000", req_done);
    end
    tick();
    n_checks++;
    if (bsy !== 1'b0 || hs !== 1'b0 || gid !== 2'd2 || lck !== 1'b0) begin
      n_fail++;
      $display("FAIL spur_state: busy=%b start=%b gid=%0d lock=%b",
               bsy, hs, gid, lck);
    end
    pulse(0, rnd_blk(), 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    n_checks++;
    if (hs !== 1'b1 || gid !== 2'd0) begin
      n_fail++;
      $display("FAIL spur_next: start=%b gid=%0d want 1/0", hs, gid);
    end
    tick();
    hdone = 1'b1;
    tick();
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int c = 0; c < N; c++) pulse(c, rnd_blk(), 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if (hs !== 1'b0 || hdi !== '0 || {ml, ci, si} !== 3'b000 ||
        {bsy, lck, ovf} !== 3'b000 || gid !== 2'd0) begin
      n_fail++;
      $display("FAIL midreset_vals: s%b b%b l%b o%b g%0d f%b",
               hs, bsy, lck, ovf, gid, {ml, ci, si});
    end
    hdone = 1'b1;
    #1;
    n_checks++;
    if (req_done !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_done: got %b want 000", req_done);
    end
    tick();
    tick();
    n_checks++;
    if (hs !== 1'b0 || bsy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idle: start=%b busy=%b", hs, bsy);
    end
  endtask

  task automatic test_random();
    int cd;
    logic [N-1:0] exp_done;
    bit exp_busy;
    do_reset();
    cd = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 3) == 0 ||
            (m_locked && !m_busy && c == m_owner))
          pulse(c, rnd_blk(), 1'($urandom_range(0, 1)),
                $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      core_dout = {8{$urandom}};
      if (m_start) cd = $urandom_range(0, 3);
      else if (m_busy) begin
        if (cd == 0) hdone = 1'b1;
        else cd--;
      end else if ($urandom_range(0, 15) == 0) hdone = 1'b1;
      #1;
      exp_done = (m_busy && hdone) ? (3'b001 << m_owner) : 3'b000;
      exp_busy = m_busy;
      for (int c = 0; c < N; c++) if (m_pend[c]) exp_busy = 1;
      n_checks++;
      if (hs !== m_start || {si, ci, ml, hdi} !== m_out) begin
        n_fail++;
        $display("FAIL rand_core c%0d: start=%b want %b dok=%b", cyc,
                 hs, m_start, {si, ci, ml, hdi} === m_out);
      end
      n_checks++;
      if (req_done !== exp_done || req_dout !== core_dout) begin
        n_fail++;
        $display("FAIL rand_done c%0d: got %b want %b", cyc,
                 req_done, exp_done);
      end
      n_checks++;
      if (bsy !== exp_busy || gid !== 2'(m_owner) ||
          lck !== m_locked || ovf !== m_ovf) begin
        n_fail++;
        $display("FAIL rand_status c%0d: bglo %b%0d%b%b want %b%0d%b%b",
                 cyc, bsy, gid, lck, ovf, exp_busy, m_owner, m_locked,
                 m_ovf);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    req_start = '0;
    req_len = '0;
    req_cont = '0;
    req_store = '0;
    req_data = '0;
    hdone = 1'b0;
    core_dout = '0;
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_overflow();
    test_spurious();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
